// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one Avalon-MM read per fetch request, big-endian
// byte swap of the returned word, and sticky halt/fault status.
module instr_fetch_unit #(
    parameter bit          SWAP_BYTES     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc_address,
    input  logic        halt_in,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_done,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic        fault_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       avm_address_q, avm_address_d;
    logic              avm_read_q, avm_read_d;
    logic [3:0]        avm_byteenable_q, avm_byteenable_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fetch_done_q, fetch_done_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              fault_timeout_q, fault_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_sw_c;

    // Memory returns little-endian lanes; the CPU sees the word big-endian.
    assign rdata_sw_c = SWAP_BYTES ? {avm_readdata[7:0],   avm_readdata[15:8],
                                      avm_readdata[23:16], avm_readdata[31:24]}
                                   : avm_readdata;

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        avm_address_d    = avm_address_q;
        avm_read_d       = avm_read_q;
        avm_byteenable_d = avm_byteenable_q;
        instr_d          = instr_q;
        instr_valid_d    = instr_valid_q;
        fetch_done_d     = 1'b0;
        busy_d           = busy_q;
        halted_d         = halted_q;
        fault_d          = fault_q;
        fault_timeout_d  = fault_timeout_q;
        cnt_d            = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    if (halt_in) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else if (pc_address[1:0] != 2'b00) begin
                        state_d         = S_FAULT;
                        fault_d         = 1'b1;
                        fault_timeout_d = 1'b0;
                    end else begin
                        state_d          = S_REQ;
                        avm_address_d    = pc_address;
                        avm_read_d       = 1'b1;
                        avm_byteenable_d = 4'hF;
                        busy_d           = 1'b1;
                        instr_valid_d    = 1'b0;
                        cnt_d            = '0;
                    end
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    state_d          = S_IDLE;
                    instr_d          = rdata_sw_c;
                    instr_valid_d    = 1'b1;
                    fetch_done_d     = 1'b1;
                    avm_read_d       = 1'b0;
                    avm_byteenable_d = 4'h0;
                    busy_d           = 1'b0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d          = S_FAULT;
                    avm_read_d       = 1'b0;
                    avm_byteenable_d = 4'h0;
                    busy_d           = 1'b0;
                    fault_d          = 1'b1;
                    fault_timeout_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // HALTED and FAULT hold everything until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_byteenable_q <= '0;
            instr_q          <= '0;
            instr_valid_q    <= 1'b0;
            fetch_done_q     <= 1'b0;
            busy_q           <= 1'b0;
            halted_q         <= 1'b0;
            fault_q          <= 1'b0;
            fault_timeout_q  <= 1'b0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            avm_address_q    <= avm_address_d;
            avm_read_q       <= avm_read_d;
            avm_byteenable_q <= avm_byteenable_d;
            instr_q          <= instr_d;
            instr_valid_q    <= instr_valid_d;
            fetch_done_q     <= fetch_done_d;
            busy_q           <= busy_d;
            halted_q         <= halted_d;
            fault_q          <= fault_d;
            fault_timeout_q  <= fault_timeout_d;
            cnt_q            <= cnt_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_byteenable = avm_byteenable_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign fetch_done     = fetch_done_q;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
    assign fault_timeout  = fault_timeout_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a swapping/no-timeout instance and a
// pass-through/timeout-4 instance share stimulus; a byte-order model predicts results.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc_address;
    logic        halt_in;
    logic        waitrequest;
    logic [31:0] readdata;

    logic [31:0] a_addr, a_instr, b_addr, b_instr;
    logic [3:0]  a_be, b_be;
    logic        a_read, a_valid, a_done, a_busy, a_halted, a_fault, a_fto;
    logic        b_read, b_valid, b_done, b_busy, b_halted, b_fault, b_fto;

    // status = {read, byteenable, busy, done, valid, halted, fault, fault_timeout}
    logic [10:0] a_st, b_st;
    assign a_st = {a_read, a_be, a_busy, a_done, a_valid, a_halted, a_fault, a_fto};
    assign b_st = {b_read, b_be, b_busy, b_done, b_valid, b_halted, b_fault, b_fto};

    localparam logic [10:0] ST_REQ    = 11'b1_1111_1_0_0_000;
    localparam logic [10:0] ST_DONE   = 11'b0_0000_0_1_1_000;
    localparam logic [10:0] ST_IDLE_V = 11'b0_0000_0_0_1_000;
    localparam logic [10:0] ST_HALT_V = 11'b0_0000_0_0_1_100;
    localparam logic [10:0] ST_MISAL  = 11'b0_0000_0_0_0_010;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    instr_fetch_unit #(.SWAP_BYTES(1'b1), .TIMEOUT_CYCLES(0)) u_a (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_address(pc_address),
        .halt_in(halt_in), .avm_address(a_addr), .avm_read(a_read),
        .avm_byteenable(a_be), .avm_waitrequest(waitrequest), .avm_readdata(readdata),
        .instr(a_instr), .instr_valid(a_valid), .fetch_done(a_done), .busy(a_busy),
        .halted(a_halted), .fault(a_fault), .fault_timeout(a_fto)
    );

    instr_fetch_unit #(.SWAP_BYTES(1'b0), .TIMEOUT_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_address(pc_address),
        .halt_in(halt_in), .avm_address(b_addr), .avm_read(b_read),
        .avm_byteenable(b_be), .avm_waitrequest(waitrequest), .avm_readdata(readdata),
        .instr(b_instr), .instr_valid(b_valid), .fetch_done(b_done), .busy(b_busy),
        .halted(b_halted), .fault(b_fault), .fault_timeout(b_fto)
    );

    // Big-endian view of a little-endian word, by plain byte arithmetic.
    function automatic logic [31:0] be_view(input logic [31:0] d);
        int unsigned v;
        v = d;
        return ((v % 256) * 32'h0100_0000) + (((v / 256) % 256) * 32'h1_0000)
             + (((v / 65536) % 256) * 256) + (v / 32'h0100_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; fetch_req = 1'b0; halt_in = 1'b0;
        waitrequest = 1'b0; pc_address = '0; readdata = '0;
        exp_a = '0; exp_b = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_req = 1'b1; halt_in = 1'b0;
        waitrequest = 1'b0; pc_address = 32'h1234_5678; readdata = $urandom();
        #3;
        n_cmp++;
        if ({a_addr, a_instr, a_st, b_addr, b_instr, b_st} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs a_st=%b a_addr=%h b_st=%b b_addr=%h want all 0",
                     a_st, a_addr, b_st, b_addr);
        end
        do_reset();
    endtask

    task automatic test_spec_vector();
        fetch_req = 1'b1; pc_address = 32'hBFC0_0000; waitrequest = 1'b0;
        readdata = 32'h7856_3412;
        tick();
        fetch_req = 1'b0;
        n_cmp++;
        if (a_st !== ST_REQ || a_addr !== 32'hBFC0_0000 || b_st !== ST_REQ) begin
            n_err++;
            $display("FAIL spec_req a_st=%b a_addr=%h b_st=%b want %b addr bfc00000",
                     a_st, a_addr, b_st, ST_REQ);
        end
        tick();
        exp_a = 32'h1234_5678; exp_b = 32'h7856_3412;
        n_cmp++;
        if (a_st !== ST_DONE || a_instr !== exp_a || b_st !== ST_DONE || b_instr !== exp_b
            || a_addr !== 32'hBFC0_0000) begin
            n_err++;
            $display("FAIL spec_done a_st=%b a_instr=%h b_st=%b b_instr=%h a_addr=%h want %b %h %h",
                     a_st, a_instr, b_st, b_instr, a_addr, ST_DONE, exp_a, exp_b);
        end
        tick();
        n_cmp++;
        if (a_st !== ST_IDLE_V || b_st !== ST_IDLE_V || a_instr !== exp_a) begin
            n_err++;
            $display("FAIL spec_done_pulse a_st=%b b_st=%b a_instr=%h want %b %h",
                     a_st, b_st, a_instr, ST_IDLE_V, exp_a);
        end
    endtask

    task automatic test_wait();
        logic [31:0] addr, data;
        int cycles;
        int n = 3;
        addr = $urandom() & 32'hFFFF_FFFC;
        data = $urandom();
        fetch_req = 1'b1; pc_address = addr; waitrequest = 1'b1; readdata = data;
        tick();
        cycles = 0;
        while (!a_done && cycles < 20) begin
            n_cmp++;
            if (a_st !== ST_REQ || a_addr !== addr || a_instr !== exp_a) begin
                n_err++;
                $display("FAIL wait_stable c=%0d a_st=%b a_addr=%h a_instr=%h want %b %h %h",
                         cycles, a_st, a_addr, a_instr, ST_REQ, addr, exp_a);
            end
            waitrequest = (cycles < n);
            fetch_req   = (cycles == 1);
            if (cycles == 1) pc_address = addr ^ 32'h0000_1000;
            tick();
            cycles++;
        end
        exp_a = be_view(data); exp_b = data;
        n_cmp++;
        if (cycles != n + 1 || a_instr !== exp_a || b_instr !== exp_b || b_st !== ST_DONE) begin
            n_err++;
            $display("FAIL wait_done cycles=%0d a_instr=%h b_instr=%h b_st=%b want %0d %h %h %b",
                     cycles, a_instr, b_instr, b_st, n + 1, exp_a, exp_b, ST_DONE);
        end
        tick();
        n_cmp++;
        if (a_st !== ST_IDLE_V || b_st !== ST_IDLE_V || a_addr !== addr) begin
            n_err++;
            $display("FAIL wait_ignored_req a_st=%b b_st=%b a_addr=%h want %b addr %h",
                     a_st, b_st, a_addr, ST_IDLE_V, addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data;
        int cycles, n;
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(2, 0)) tick();
            addr = $urandom() & 32'hFFFF_FFFC;
            n = int'($urandom_range(3, 0));
            data = $urandom();
            fetch_req = 1'b1; pc_address = addr; readdata = $urandom();
            waitrequest = 1'b0;
            tick();
            cycles = 0;
            while (!a_done && cycles < 20) begin
                n_cmp++;
                if (a_st !== ST_REQ || b_st !== ST_REQ || a_addr !== addr || a_instr !== exp_a) begin
                    n_err++;
                    $display("FAIL rand_req it=%0d c=%0d a_st=%b b_st=%b a_addr=%h a_instr=%h want %b %h %h",
                             it, cycles, a_st, b_st, a_addr, a_instr, ST_REQ, addr, exp_a);
                end
                waitrequest = (cycles < n);
                readdata    = (cycles < n) ? $urandom() : data;
                fetch_req   = ($urandom_range(1, 0) == 1);
                pc_address  = $urandom();
                tick();
                cycles++;
            end
            fetch_req = 1'b0;
            exp_a = be_view(data); exp_b = data;
            n_cmp++;
            if (cycles != n + 1 || a_st !== ST_DONE || b_st !== ST_DONE
                || a_instr !== exp_a || b_instr !== exp_b) begin
                n_err++;
                $display("FAIL rand_done it=%0d cycles=%0d a_st=%b a_instr=%h b_instr=%h want %0d %h %h",
                         it, cycles, a_st, a_instr, b_instr, n + 1, exp_a, exp_b);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        fetch_req = 1'b1; halt_in = 1'b1; pc_address = '0; waitrequest = 1'b0;
        tick();
        halt_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (a_st !== ST_HALT_V || b_st !== ST_HALT_V || a_instr !== exp_a || b_instr !== exp_b) begin
                n_err++;
                $display("FAIL halt_sticky i=%0d a_st=%b b_st=%b a_instr=%h b_instr=%h want %b %h %h",
                         i, a_st, b_st, a_instr, b_instr, ST_HALT_V, exp_a, exp_b);
            end
            fetch_req = 1'b1; pc_address = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        do_reset();
    endtask

    task automatic test_misaligned();
        logic [31:0] tmp;
        tmp = $urandom();
        fetch_req = 1'b1;
        pc_address = {tmp[31:2], 2'($urandom_range(3, 1))};
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (a_st !== ST_MISAL || b_st !== ST_MISAL || a_addr !== '0) begin
                n_err++;
                $display("FAIL misaligned i=%0d a_st=%b b_st=%b a_addr=%h want %b addr 0",
                         i, a_st, b_st, a_addr, ST_MISAL);
            end
            pc_address = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        do_reset();
    endtask

    task automatic test_timeout();
        fetch_req = 1'b1; pc_address = 32'h0000_0100; waitrequest = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b_st !== ST_REQ || b_addr !== 32'h0000_0100) begin
                n_err++;
                $display("FAIL timeout_hold k=%0d b_st=%b b_addr=%h want %b addr 100",
                         k, b_st, b_addr, ST_REQ);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({b_read, b_busy, b_done, b_valid, b_halted, b_fault, b_fto} !== 7'b0000011
                || a_st !== ST_REQ) begin
                n_err++;
                $display("FAIL timeout_fault k=%0d b_st=%b a_st=%b want rd0 fault1 fto1, a %b",
                         k, b_st, a_st, ST_REQ);
            end
            fetch_req = (k == 0);
            tick();
        end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] data;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (a_read !== 1'b0 || a_busy !== 1'b0 || a_addr !== '0 || b_fault !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async a_read=%b a_busy=%b a_addr=%h b_fault=%b want 0",
                     a_read, a_busy, a_addr, b_fault);
        end
        do_reset();
        data = $urandom();
        fetch_req = 1'b1; pc_address = 32'h0000_2000; waitrequest = 1'b0; readdata = data;
        tick();
        fetch_req = 1'b0;
        tick();
        exp_a = be_view(data); exp_b = data;
        n_cmp++;
        if (a_st !== ST_DONE || b_st !== ST_DONE || a_instr !== exp_a || b_instr !== exp_b) begin
            n_err++;
            $display("FAIL after_reset a_st=%b b_st=%b a_instr=%h b_instr=%h want %b %h %h",
                     a_st, b_st, a_instr, b_instr, ST_DONE, exp_a, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_wait();
        test_random();
        test_halt();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Memory-side counterpart of the program counter. Takes the PC address when the control FSM requests a fetch and runs one Avalon-MM read on the instruction bus. It honours waitrequest, byte-swaps the returned word into the CPU's big-endian view, and holds the instruction for the decode/exec stages. It also turns the PC halt indication and bus faults into sticky status flags for the CPU top level.

Parameters:
SWAP_BYTES, 1, when 1 instr = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}; when 0 readdata is passed through unchanged
TIMEOUT_CYCLES, 0, maximum number of waitrequest-high cycles tolerated in REQ before a timeout; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
fetch_req  input  1  one-cycle request from the control FSM to fetch at pc_address
pc_address  input  32  instruction address from the PC
halt_in  input  1  halt indication from the PC (PC address == 0)
avm_address  output  32  Avalon read address
avm_read  output  1  Avalon read strobe
avm_byteenable  output  4  Avalon byte enables
avm_waitrequest  input  1  Avalon stall
avm_readdata  input  32  Avalon read data
instr  output  32  fetched instruction word, after byte swap
instr_valid  output  1  instr holds the result of the most recent completed fetch
fetch_done  output  1  one-cycle pulse when a fetch completes
busy  output  1  a read is outstanding
halted  output  1  sticky: CPU halted
fault  output  1  sticky: misaligned address or bus timeout
fault_timeout  output  1  sticky: the fault was a timeout (0 = misaligned)

Behaviour:
- reset=0, asynchronously: state IDLE; every output 0, including avm_address and instr; wait counter 0.
- A read in flight when reset asserts is abandoned immediately: avm_read drops asynchronously.
- States: IDLE, REQ, HALTED, FAULT.
- IDLE, fetch_req=1, priority order:
  - halt_in=1 -> HALTED, halted<=1, no bus access.
  - else pc_address[1:0]!=0 -> FAULT, fault<=1, fault_timeout<=0.
  - else avm_address<=pc_address, avm_read<=1, avm_byteenable<=4'hF, busy<=1, instr_valid<=0, counter<=0 -> REQ.
- IDLE, fetch_req=0: no change.
- REQ: avm_address, avm_read and avm_byteenable stay stable until the read is accepted.
  - waitrequest=1: stay in REQ; counter increments and saturates.
  - waitrequest=0 (read accepted): instr<=swap(readdata), instr_valid<=1, fetch_done<=1 for exactly one cycle, avm_read<=0, avm_byteenable<=0, busy<=0 -> IDLE. avm_address keeps its last value.
  - TIMEOUT_CYCLES!=0, waitrequest=1 and counter==TIMEOUT_CYCLES-1: drop avm_read, busy<=0, fault<=1, fault_timeout<=1 -> FAULT.
- fetch_req in REQ, HALTED or FAULT is ignored; requests are not queued.
- HALTED and FAULT are absorbing until reset. Bus idle. instr and instr_valid keep their last values.
- Latency:
  - fetch_req sampled at edge N -> avm_read high from edge N.
  - waitrequest low in cycle N..N+1 -> instr valid and fetch_done high after edge N+1.
  - Minimum request-to-done latency: 2 cycles; each waitrequest-high cycle adds 1.
- fetch_done=1 exactly when instr_valid rises. instr changes only on a completed fetch.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. Address arithmetic is never performed here; pc_address is used as given.

Test Plan:
- reset=0 -> all outputs 0. fetch_req=1, pc_address=32'hBFC00000, waitrequest=0, readdata=32'h78563412 -> avm_read high for 1 cycle at BFC00000 with byteenable F; fetch_done one cycle later; instr=32'h12345678, instr_valid=1.
- Same fetch with waitrequest high for 3 cycles -> address and read stable for 4 cycles; fetch_done 5 cycles after request; fetch_req pulsed while busy is ignored.
- fetch_req with halt_in=1, pc_address=0 -> halted=1, avm_read never asserts; later fetch_reqs ignored until reset.
- pc_address=32'hBFC00002 -> fault=1, fault_timeout=0, no bus read; sticky across further requests.
- TIMEOUT_CYCLES=4, waitrequest held high -> avm_read drops after 4 cycles; fault=1, fault_timeout=1, no fetch_done.
- reset asserted mid-REQ -> avm_read 0 immediately; after release, a fresh fetch completes normally with SWAP_BYTES=0 passing readdata through.
